// File: rtl/tt_counter_pkg.sv
// Shared definitions for the parametrised Tiny Tapeout counter.
//   seq_t     : load/bus-turnaround sequencer states (encoding is visible in
//               the status byte, so the values are fixed)
//   ST_*      : bit positions inside the status byte
//   CTRL_*    : bit positions inside ui_in / ctrl_q
//   idx_width : index width for n items, never less than 1 bit
package tt_counter_pkg;

    typedef enum logic [1:0] {
        DRIVE   = 2'd0,
        RELEASE = 2'd1,
        CAPTURE = 2'd2
    } seq_t;

    localparam int ST_WRAP = 7;
    localparam int ST_TERM = 6;
    localparam int ST_DIR  = 5;
    localparam int ST_SAT  = 4;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_LOAD    = 1;
    localparam int CTRL_OE      = 2;
    localparam int CTRL_DIR     = 3;
    localparam int CTRL_SAT     = 4;
    localparam int CTRL_BSEL_LO = 5;
    localparam int CTRL_BSEL_HI = 6;
    localparam int CTRL_STAT    = 7;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tt_ctrl_sync.sv
// Control input register with rising-edge detect on the load bit.
//   clk, rst_n : clock, asynchronous active-low reset
//   ui_in      : raw control pins
//   ctrl_q     : ui_in registered once; every control decision uses this
//   load_pulse : one-cycle pulse on a 0->1 transition of ctrl_q[CTRL_LOAD]
module tt_ctrl_sync
    import tt_counter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] ctrl_q,
    output logic       load_pulse
);

    logic [7:0] ctrl_d;
    logic       load_q;
    logic       load_d;

    always_comb begin
        ctrl_d = ui_in;
        load_d = ctrl_q[CTRL_LOAD];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= 8'h00;
            load_q <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            load_q <= load_d;
        end
    end

    assign load_pulse = ctrl_q[CTRL_LOAD] & ~load_q;

endmodule

// File: rtl/tt_um_param_counter.sv
// Tiny Tapeout user top: WIDTH-bit up/down counter with wrap or saturate,
// byte-wise parallel load over the bidirectional bus and a status byte.
//   clk, rst_n : clock, asynchronous active-low reset
//   ui_in      : {status_sel, byte_sel[1:0], sat, dir, oe, load, en}
//   uo_out     : selected count byte, or status byte when status_sel = 1
//   uio_in     : load data, least significant byte first
//   uio_out    : selected count byte
//   uio_oe     : all ones while the bus is driven, else all zeros
//   ena        : unused
module tt_um_param_counter
    import tt_counter_pkg::*;
#(
    parameter int   WIDTH         = 16,   // 8, 16, 24 or 32
    parameter logic DEFAULT_EN    = 1'b1,
    parameter logic DEFAULT_DRIVE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena
);

    localparam int              NBYTES   = WIDTH / 8;
    localparam int              BW       = idx_width(NBYTES);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [BW-1:0]   LAST_IDX = BW'(NBYTES - 1);
    localparam logic [BW-1:0]   IDX_ONE  = BW'(1);

    logic [7:0]       ctrl_q;
    logic             load_pulse;

    seq_t             seq_q,   seq_d;
    logic [BW-1:0]    bidx_q,  bidx_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q,  wrap_d;

    logic             en, oe, dir_dn, sat_mode, at_term, driving;
    logic [7:0]       sel_byte;
    logic [7:0]       status;

    tt_ctrl_sync u_ctrl_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .ui_in      (ui_in),
        .ctrl_q     (ctrl_q),
        .load_pulse (load_pulse)
    );

    assign en       = DEFAULT_EN    | ctrl_q[CTRL_EN];
    assign oe       = DEFAULT_DRIVE | ctrl_q[CTRL_OE];
    assign dir_dn   = ctrl_q[CTRL_DIR];
    assign sat_mode = ctrl_q[CTRL_SAT];
    assign at_term  = dir_dn ? (count_q == '0) : (count_q == CNT_MAX);

    // Sequencer, counter and wrap flag. The bus is released for one full
    // cycle before the first capture edge so the external driver never
    // fights uio_out. Byte bidx is sampled on the edge that ends the
    // CAPTURE cycle carrying that index.
    always_comb begin
        seq_d   = seq_q;
        bidx_d  = bidx_q;
        count_d = count_q;
        wrap_d  = wrap_q;
        unique case (seq_q)
            DRIVE: begin
                if (load_pulse) begin
                    seq_d = RELEASE;
                end
                if (en) begin
                    if (at_term) begin
                        if (!sat_mode) begin
                            count_d = dir_dn ? CNT_MAX : '0;
                            wrap_d  = 1'b1;
                        end
                    end else begin
                        count_d = dir_dn ? (count_q - CNT_ONE) : (count_q + CNT_ONE);
                    end
                end
            end
            RELEASE: begin
                seq_d  = CAPTURE;
                bidx_d = '0;
            end
            CAPTURE: begin
                for (int k = 0; k < NBYTES; k++) begin
                    if (bidx_q == BW'(k)) begin
                        count_d[8*k +: 8] = uio_in;
                    end
                end
                if (bidx_q == LAST_IDX) begin
                    seq_d  = DRIVE;
                    wrap_d = 1'b0;
                end else begin
                    bidx_d = bidx_q + IDX_ONE;
                end
            end
            default: begin
                seq_d = DRIVE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q   <= DRIVE;
            bidx_q  <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            seq_q   <= seq_d;
            bidx_q  <= bidx_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    // byte_sel wraps modulo the byte count, so narrow builds alias bytes.
    always_comb begin
        int sel;
        sel      = int'(ctrl_q[CTRL_BSEL_HI:CTRL_BSEL_LO]) % NBYTES;
        sel_byte = count_q[7:0];
        for (int k = 0; k < NBYTES; k++) begin
            if (sel == k) begin
                sel_byte = count_q[8*k +: 8];
            end
        end
    end

    always_comb begin
        status          = 8'h00;
        status[ST_WRAP] = wrap_q;
        status[ST_TERM] = at_term;
        status[ST_DIR]  = dir_dn;
        status[ST_SAT]  = sat_mode;
        status[1:0]     = seq_q;
    end

    assign driving = (seq_q == DRIVE) & oe;
    assign uo_out  = ctrl_q[CTRL_STAT] ? status : sel_byte;
    assign uio_out = sel_byte;
    assign uio_oe  = {8{driving}};

    // ena is a harness pin with no function here; the raw load level is only
    // consumed through load_pulse.
    logic unused_ok;
    assign unused_ok = ena ^ ctrl_q[CTRL_LOAD];

endmodule

// File: tb/tb_tt_um_param_counter.sv
module tb_tt_um_param_counter;

    localparam int W  = 16;
    localparam int NB = W / 8;
    localparam longint unsigned MAXV = (64'd1 << W) - 1;
    localparam bit DEF_EN = 1'b1;

    logic       clk, rst_n, ena;
    logic [7:0] ui_in, uio_in;
    logic [7:0] uo_out, uio_out, uio_oe;
    logic [7:0] uo_out2, uio_out2, uio_oe2;

    tt_um_param_counter #(.WIDTH(W), .DEFAULT_EN(1'b1), .DEFAULT_DRIVE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
        .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe), .ena(ena)
    );

    // Same stimulus, bus only driven when ui_in[2] asks for it.
    tt_um_param_counter #(.WIDTH(W), .DEFAULT_EN(1'b1), .DEFAULT_DRIVE(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out2),
        .uio_in(uio_in), .uio_out(uio_out2), .uio_oe(uio_oe2), .ena(ena)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: phase 0 = bus driven/counting, 1 = bus released,
    // 2.. = receiving byte (phase-2).
    longint unsigned m_cnt;
    bit              m_wrap;
    int              m_phase;
    logic [7:0]      m_ctrl;
    bit              m_loadq;
    logic [31:0]     ld_val;

    typedef struct {
        logic [7:0] ui;
        int         edges;
        logic [7:0] exp_uo;
        logic [7:0] exp_uio;
    } vec_t;
    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_cnt = 0; m_wrap = 0; m_phase = 0; m_ctrl = 8'h00; m_loadq = 0;
    endtask

    task automatic model_step();
        logic [7:0] c;
        bit         pulse;
        int         k;
        c     = m_ctrl;
        pulse = c[1] && !m_loadq;
        if (m_phase == 0) begin
            if (DEF_EN || c[0]) begin
                if (!c[3]) begin
                    if (m_cnt != MAXV) m_cnt = m_cnt + 1;
                    else if (!c[4]) begin m_cnt = 0; m_wrap = 1; end
                end else begin
                    if (m_cnt != 0) m_cnt = m_cnt - 1;
                    else if (!c[4]) begin m_cnt = MAXV; m_wrap = 1; end
                end
            end
            if (pulse) m_phase = 1;
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else begin
            k = m_phase - 2;
            m_cnt = (m_cnt & ~(64'hFF << (8 * k))) | (longint'(uio_in) << (8 * k));
            if (k == NB - 1) begin m_phase = 0; m_wrap = 0; end
            else m_phase = m_phase + 1;
        end
        m_loadq = c[1];
        m_ctrl  = ui_in;
    endtask

    task automatic model_check();
        logic [7:0] sel, status, exp_uo;
        logic [1:0] sq;
        bit         term;
        sel    = 8'((m_cnt >> (8 * (int'(m_ctrl[6:5]) % NB))) & 64'hFF);
        term   = m_ctrl[3] ? (m_cnt == 0) : (m_cnt == MAXV);
        sq     = (m_phase == 0) ? 2'd0 : (m_phase == 1) ? 2'd1 : 2'd2;
        status = {m_wrap, term, m_ctrl[3], m_ctrl[4], 2'b00, sq};
        exp_uo = m_ctrl[7] ? status : sel;
        check("uo_out",   uo_out,   exp_uo);
        check("uio_out",  uio_out,  sel);
        check("uio_oe",   uio_oe,   (m_phase == 0) ? 8'hFF : 8'h00);
        check("uo_out2",  uo_out2,  exp_uo);
        check("uio_out2", uio_out2, sel);
        check("uio_oe2",  uio_oe2,  (m_phase == 0 && m_ctrl[2]) ? 8'hFF : 8'h00);
    endtask

    // External bus driver: presents byte k of ld_val while the model is
    // waiting for byte k, random noise otherwise.
    task automatic tick();
        if (m_phase >= 2) uio_in = 8'(ld_val >> (8 * (m_phase - 2)));
        else              uio_in = 8'($urandom);
        @(posedge clk);
        model_step();
        #1;
        model_check();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst uo_out",  uo_out,  8'h00);
        check("rst uio_out", uio_out, 8'h00);
        check("rst uio_oe",  uio_oe,  8'hFF);
        check("rst uio_oe2", uio_oe2, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic do_load(input logic [31:0] v, input logic [7:0] base, output int lowc);
        ld_val = v;
        ui_in  = base | 8'h02;
        tick();
        ui_in  = base;
        tick();
        lowc = 0;
        for (int i = 0; i < 20 && uio_oe == 8'h00; i++) begin
            lowc++;
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lowc, rel;
        tbl[0] = '{8'h00, 300, 8'h2C, 8'h2C};  // 300 = 0x012C
        tbl[1] = '{8'h20, 1,   8'h01, 8'h01};  // 301, byte 1
        tbl[2] = '{8'h40, 1,   8'h2E, 8'h2E};  // 302, byte_sel 2 -> byte 0
        tbl[3] = '{8'h80, 1,   8'h00, 8'h2F};  // 303, status view
        tbl[4] = '{8'h88, 1,   8'h20, 8'h30};  // 304, dir shows in status only
        tbl[5] = '{8'h08, 1,   8'h2F, 8'h2F};  // counting down now: 303
        tbl[6] = '{8'h68, 1,   8'h01, 8'h01};  // 302, byte_sel 3 -> byte 1

        ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00; ld_val = 0;
        model_reset();
        do_reset();

        for (int i = 0; i < 7; i++) begin
            ui_in = tbl[i].ui;
            repeat (tbl[i].edges) tick();
            check($sformatf("tbl[%0d] uo_out", i),  uo_out,  tbl[i].exp_uo);
            check($sformatf("tbl[%0d] uio_out", i), uio_out, tbl[i].exp_uio);
        end

        // Multi-byte load
        ui_in = 8'h00; tick();
        do_load(32'h1234, 8'h00, lowc);
        check("load oe low cycles", lowc, 1 + NB);
        check("load value lo", uo_out, 8'h34);
        tick();
        check("load +1 lo", uo_out, 8'h35);

        // Up wrap
        do_load(32'hFFFE, 8'h80, lowc);
        check("upwrap start", uio_out, 8'hFE);
        tick(); check("upwrap max", uio_out, 8'hFF); check("upwrap flag pre", uo_out[7], 1'b0);
        tick(); check("upwrap zero", uio_out, 8'h00); check("upwrap flag", uo_out[7], 1'b1);
        repeat (3) tick();
        check("upwrap flag sticky", uo_out[7], 1'b1);

        // Down wrap; the load clears the flag
        do_load(32'h0001, 8'h88, lowc);
        check("load clears wrap", uo_out[7], 1'b0);
        check("dnwrap start", uio_out, 8'h01);
        tick(); check("dnwrap zero", uio_out, 8'h00); check("dnwrap term", uo_out[6], 1'b1);
        tick(); check("dnwrap max", uio_out, 8'hFF); check("dnwrap flag", uo_out[7], 1'b1);

        // Saturate
        do_load(32'hFFFD, 8'h90, lowc);
        repeat (4) tick();
        check("sat hold", uio_out, 8'hFF);
        check("sat term", uo_out[6], 1'b1);
        check("sat no wrap", uo_out[7], 1'b0);
        ui_in = 8'h98;
        tick(); check("sat dir +1 edge", uio_out, 8'hFF);
        tick(); check("sat dir +2 edge", uio_out, 8'hFE);

        // Load toggled mid-sequence: one RELEASE only
        ui_in = 8'h80; tick();
        rel = 0;
        ui_in = 8'h82; tick(); if (uo_out[1:0] == 2'd1) rel++;
        ui_in = 8'h80; tick(); if (uo_out[1:0] == 2'd1) rel++;
        ui_in = 8'h82; tick(); if (uo_out[1:0] == 2'd1) rel++;
        ui_in = 8'h80;
        repeat (15) begin tick(); if (uo_out[1:0] == 2'd1) rel++; end
        check("toggle single seq", rel, 1);

        // Load held high: one sequence
        rel = 0;
        ui_in = 8'h82;
        repeat (50) begin tick(); if (uo_out[1:0] == 2'd1) rel++; end
        ui_in = 8'h80;
        repeat (10) begin tick(); if (uo_out[1:0] == 2'd1) rel++; end
        check("held load single seq", rel, 1);

        // Reset after byte 0 captured
        ld_val = 32'hABCD;
        ui_in = 8'h82; tick();
        ui_in = 8'h80;
        for (int i = 0; i < 10 && m_phase != 3; i++) tick();
        check("mid-capture reached", m_phase, 3);
        do_reset();
        tick();
        check("post-rst status", uo_out, 8'h00);
        check("post-rst count", uio_out, 8'h01);

        // Bus only driven when requested in the DEFAULT_DRIVE = 0 build
        repeat (3) tick();
        check("nodrive oe off", uio_oe2, 8'h00);
        ui_in = 8'h84; tick();
        check("nodrive oe on", uio_oe2, 8'hFF);

        // Randomised run against the model
        for (int i = 0; i < 2000; i++) begin
            if (m_phase == 0) begin
                case ($urandom_range(0, 5))
                    0: ld_val = 32'hFFFE;
                    1: ld_val = 32'h0001;
                    2: ld_val = 32'hFFFD;
                    3: ld_val = 32'h0000;
                    4: ld_val = 32'hFFFF;
                    default: ld_val = $urandom & 32'hFFFF;
                endcase
            end
            ui_in    = 8'($urandom);
            ui_in[1] = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
